// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D conversion scheduler
package a2d_pkg;
    localparam int SMPL_W = 12;
    typedef enum logic [2:0] {IDLE, CMD1, WAIT1, DEAD, CMD2, WAIT2, CAPT} state_t;
    localparam logic [2:0] SLOT_CH [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
endpackage

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin A2D channel scheduler issuing two SPI transactions per conversion
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int DEAD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nxt,
    input  logic              spi_done,
    input  logic [15:0]       spi_rd_data,
    output logic              spi_wrt,
    output logic [15:0]       spi_cmd,
    output logic [SMPL_W-1:0] lft_ld,
    output logic [SMPL_W-1:0] rght_ld,
    output logic [SMPL_W-1:0] steer_pot,
    output logic [SMPL_W-1:0] batt,
    output logic              busy,
    output logic              round_done
);
    state_t            state;
    logic [1:0]        slot;
    logic [3:0]        dead_cnt;
    logic [SMPL_W-1:0] smpl;

    // the command word only follows the slot, which moves solely in CAPT, so it is stable across both transactions
    assign spi_wrt = (state == CMD1) || (state == CMD2);
    assign spi_cmd = {2'b00, SLOT_CH[slot], 11'h000};
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= 2'd0;
            dead_cnt   <= 4'd0;
            smpl       <= '0;
            lft_ld     <= '0;
            rght_ld    <= '0;
            steer_pot  <= '0;
            batt       <= '0;
            round_done <= 1'b0;
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE:  if (nxt) state <= CMD1;
                CMD1:  state <= WAIT1;
                WAIT1: if (spi_done) begin
                    state    <= DEAD;
                    dead_cnt <= 4'(DEAD_CYC);
                end
                DEAD: begin
                    dead_cnt <= dead_cnt - 4'd1;
                    if (dead_cnt <= 4'd1) state <= CMD2;
                end
                CMD2:  state <= WAIT2;
                WAIT2: if (spi_done) begin
                    smpl  <= spi_rd_data[SMPL_W-1:0];
                    state <= CAPT;
                end
                CAPT: begin
                    case (slot)
                        2'd0:    lft_ld    <= smpl;
                        2'd1:    rght_ld   <= smpl;
                        2'd2:    steer_pot <= smpl;
                        default: batt      <= smpl;
                    endcase
                    round_done <= slot == 2'd3;
                    slot       <= slot + 2'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: scoreboard bench for a2d_sched with a task-driven SPI responder
module tb_a2d_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd_data = 16'h0;
    logic        spi_wrt, busy, round_done;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] cmd_q [$];
    logic [11:0] exp_ld [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    logic [1:0]  exp_slot = 2'd0;
    logic [15:0] cmd_tab [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};

    a2d_sched #(.DEAD_CYC(3)) u_dut (
        .clk(clk), .rst(rst), .nxt(nxt), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .busy(busy), .round_done(round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // every spi_wrt pulse must match the next queued command
    always @(negedge clk) begin
        if (!rst && spi_wrt) begin
            if (cmd_q.size() == 0) chk("wrt_unexpected", 32'd1, 32'd0);
            else chk("spi_cmd", {16'h0, spi_cmd}, {16'h0, cmd_q.pop_front()});
        end
    end

    task automatic chk_outs(input string tag);
        chk({tag, "_lft"}, {20'h0, lft_ld}, {20'h0, exp_ld[0]});
        chk({tag, "_rght"}, {20'h0, rght_ld}, {20'h0, exp_ld[1]});
        chk({tag, "_steer"}, {20'h0, steer_pot}, {20'h0, exp_ld[2]});
        chk({tag, "_batt"}, {20'h0, batt}, {20'h0, exp_ld[3]});
    endtask

    task automatic wait_wrt(output int n);
        n = 1;
        while (!spi_wrt && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // one full conversion; inj pulses nxt during WAIT1 and CAPT, which must be dropped
    task automatic conv(input logic [11:0] v, input logic [3:0] hi, input bit inj);
        int n;
        cmd_q.push_back(cmd_tab[exp_slot]);
        cmd_q.push_back(cmd_tab[exp_slot]);
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        chk("wrt1_latency", {31'h0, spi_wrt}, 32'd1);
        chk("busy_on", {31'h0, busy}, 32'd1);
        @(negedge clk) nxt = inj;
        @(negedge clk) nxt = 1'b0;
        spi_done = 1'b1;
        spi_rd_data = 16'h0DEF;
        @(negedge clk) spi_done = 1'b0;
        spi_rd_data = 16'h0;
        wait_wrt(n);
        chk("dead_gap", n, 32'd4);
        @(negedge clk);
        @(negedge clk);
        spi_done = 1'b1;
        spi_rd_data = {hi, v};
        @(negedge clk) spi_done = 1'b0;
        spi_rd_data = 16'h0;
        nxt = inj;
        @(negedge clk) nxt = 1'b0;
        exp_ld[exp_slot] = v;
        chk("round_done", {31'h0, round_done}, {31'h0, exp_slot == 2'd3});
        exp_slot = exp_slot + 2'd1;
        chk("busy_off", {31'h0, busy}, 32'd0);
        chk_outs("conv");
        @(negedge clk);
        chk("round_done_1clk", {31'h0, round_done}, 32'd0);
        chk("idle_after", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_wrt", {31'h0, spi_wrt}, 32'd0);
        chk("rst_cmd", {16'h0, spi_cmd}, 32'h0);
        chk_outs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        conv(12'hABC, 4'h0, 1'b0);
        conv(12'h222, 4'hA, 1'b0);
        conv(12'h333, 4'h5, 1'b1);
        conv(12'h444, 4'hF, 1'b0);
        conv(12'h111, 4'h3, 1'b0);
        conv(12'h5A5, 4'h9, 1'b1);
        spi_done = 1'b1;
        spi_rd_data = 16'h0777;
        @(negedge clk) spi_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_busy", {31'h0, busy}, 32'd0);
        chk_outs("spur");
        cmd_q.push_back(cmd_tab[exp_slot]);
        cmd_q.push_back(cmd_tab[exp_slot]);
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        @(negedge clk);
        spi_done = 1'b1;
        @(negedge clk) spi_done = 1'b0;
        begin
            int n;
            wait_wrt(n);
        end
        @(negedge clk);
        spi_rd_data = 16'h0FFF;
        #2 rst = 1'b1;
        #1;
        exp_ld = '{12'h0, 12'h0, 12'h0, 12'h0};
        exp_slot = 2'd0;
        chk("rstmid_busy", {31'h0, busy}, 32'd0);
        chk("rstmid_wrt", {31'h0, spi_wrt}, 32'd0);
        chk("rstmid_cmd", {16'h0, spi_cmd}, 32'h0);
        chk_outs("rstmid");
        chk("rstmid_q_empty", cmd_q.size(), 32'd0);
        @(negedge clk) rst = 1'b0;
        spi_rd_data = 16'h0;
        @(negedge clk);
        conv(12'h9C3, 4'h2, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_q_empty", cmd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
